// File: rtl/hm_memory_reader_if.sv
// Memory port-B bus and outgoing word stream of hm_memory_reader.
// master = reader side, slave = memory/consumer side.
interface hm_memory_reader_if;
  logic [15:0] MEM_ADDR;
  logic [3:0]  MEM_WE;
  logic [31:0] MEM_DI;
  logic [31:0] MEM_DO;
  logic [31:0] DATA;
  logic        VALID;
  logic        READY;
  logic        LAST;

  modport master (
    output MEM_ADDR, MEM_WE, MEM_DI, DATA, VALID, LAST,
    input  MEM_DO, READY
  );

  modport slave (
    input  MEM_ADDR, MEM_WE, MEM_DI, DATA, VALID, LAST,
    output MEM_DO, READY
  );
endinterface

// File: rtl/hm_memory_reader.sv
// Streams LEN words from hm_memory_32 port B through a small FIFO that hides read latency.
// Optional macro HM_READER_ABORT_EN adds an ABORT input that flushes and cancels a transfer.
module hm_memory_reader #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 11
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [11:0]        BASE,
  input  logic [LEN_W-1:0]   LEN,
`ifdef HM_READER_ABORT_EN
  input  logic               ABORT,
`endif
  output logic               BUSY,
  output logic               DONE,
  hm_memory_reader_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

  typedef enum logic [1:0] { S_IDLE, S_RUN, S_DRAIN } state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [11:0]      byte_idx;
  logic [LEN_W-1:0] remaining;
  logic             vld_p1;
  logic             last_p1;
  logic [31:0]      fifo_data [DEPTH];
  logic             fifo_tag  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             issue, final_issue, push, pop, head_last, abort_req;

`ifdef HM_READER_ABORT_EN
  assign abort_req = ABORT && (state_q != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Slots already promised: stored words plus the read whose data lands next edge
  assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p1};
  assign issue       = (state_q == S_RUN) && (occupancy < DEPTH_V) && !abort_req;
  assign final_issue = issue && (remaining == LEN_W'(1));
  assign push        = vld_p1;
  assign pop         = (fifo_count != '0) && bus.READY && !abort_req;
  assign head_last   = fifo_tag[rd_ptr];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LEN != '0) state_d = S_RUN;
          else           done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (final_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_req) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // p0: address issue
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_idx  <= '0;
      remaining <= '0;
    end else if ((state_q == S_IDLE) && START && (LEN != '0)) begin
      byte_idx  <= BASE & 12'hFFC;
      remaining <= LEN;
    end else if (issue) begin
      byte_idx  <= byte_idx + 12'd4;
      remaining <= remaining - LEN_W'(1);
    end
  end

  // p1: memory data valid, captured into the FIFO
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= final_issue;
      if (abort_req) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CNT_W'(1);
          2'b01:   fifo_count <= fifo_count - CNT_W'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !abort_req) begin
      fifo_data[wr_ptr] <= bus.MEM_DO;
      fifo_tag[wr_ptr]  <= last_p1;
    end
  end

  assign bus.MEM_ADDR = {1'b0, byte_idx, 3'b000};
  assign bus.MEM_WE   = 4'b0000;
  assign bus.MEM_DI   = 32'd0;
  assign bus.VALID    = (fifo_count != '0);
  assign bus.DATA     = bus.VALID ? fifo_data[rd_ptr] : 32'd0;
  assign bus.LAST     = bus.VALID && head_last;
  assign BUSY         = (state_q != S_IDLE);
  assign DONE         = done_q;

endmodule

// File: tb/tb_hm_memory_reader.sv
// Randomised bench for hm_memory_reader with a word-array memory model and a stream scoreboard.
`timescale 1ns/1ps
module tb_hm_memory_reader;
  localparam int LEN_W = 11;

  logic             clk, rst_n, start, abort;
  logic [11:0]      base;
  logic [LEN_W-1:0] len;
  logic             busy, done;
  hm_memory_reader_if bif ();

  logic [31:0] mem [1024];
  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cycles;
    int first_vld;
    int valid_cycles;
    int stall_err;
    int max_off;
    bit busy_at_done;
    bit timed_out;
  } res_t;

  hm_memory_reader #(.DEPTH(4), .LEN_W(LEN_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .START (start),
    .BASE  (base),
    .LEN   (len),
`ifdef HM_READER_ABORT_EN
    .ABORT (abort),
`endif
    .BUSY  (busy),
    .DONE  (done),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory: data for the sampled address appears after the edge
  always @(posedge clk) bif.MEM_DO <= mem[bif.MEM_ADDR[14:5]];

  always @(negedge clk) begin
    if (rst_n && bif.VALID && bif.READY && !abort) begin
      got_d.push_back(bif.DATA);
      got_l.push_back(bif.LAST);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void load_pattern();
    for (int w = 0; w < 1024; w++) mem[w] = {4{w[7:0]}};
  endfunction

  function automatic void build_exp(input logic [11:0] b, input int n);
    exp_d.delete();
    exp_l.delete();
    for (int k = 0; k < n; k++) begin
      exp_d.push_back(mem[(int'(b[11:2]) + k) % 1024]);
      exp_l.push_back(k == n - 1);
    end
  endfunction

  function automatic int stream_errs();
    int e = 0;
    int m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    if (got_d.size() != exp_d.size()) e++;
    for (int k = 0; k < m; k++)
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) e++;
    return e;
  endfunction

  task automatic run_xfer(input logic [11:0] b, input int n, input logic [31:0] pat,
                          input int pat_len, output res_t r);
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [11:0] off;
    logic [11:0] b_al;
    b_al = b & 12'hFFC;
    got_d.delete();
    got_l.delete();
    build_exp(b, n);
    r = '{cycles: 0, first_vld: -1, valid_cycles: 0, stall_err: 0, max_off: 0,
          busy_at_done: 1'b0, timed_out: 1'b1};
    start = 1'b1;
    base  = b;
    len   = LEN_W'(n);
    step();
    start = 1'b0;
    base  = 12'($urandom);
    len   = LEN_W'($urandom);
    for (int c = 1; c <= 8 * n + 100; c++) begin
      bif.READY = (pat_len == 0) ? 1'($urandom_range(0, 1)) : pat[(c - 1) % pat_len];
      pv = bif.VALID; pd = bif.DATA; pl = bif.LAST; pr = bif.READY;
      step();
      if (pv && !pr && (bif.VALID !== 1'b1 || bif.DATA !== pd || bif.LAST !== pl))
        r.stall_err++;
      if (bif.VALID) begin
        r.valid_cycles++;
        if (r.first_vld < 0) r.first_vld = c;
      end
      off = bif.MEM_ADDR[14:3] - b_al;
      if (int'(off) > r.max_off) r.max_off = int'(off);
      if (done) begin
        r.cycles       = c;
        r.busy_at_done = busy;
        r.timed_out    = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; len = '0; bif.READY = 1'b0;
    step();
    step();
    n_tests++;
    if ({busy, done, bif.VALID, bif.LAST} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl busy/done/valid/last=%b required 0000",
               {busy, done, bif.VALID, bif.LAST});
    end
    n_tests++;
    if (bif.DATA !== 32'd0 || bif.MEM_ADDR !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data data=%h addr=%h required 0/0", bif.DATA, bif.MEM_ADDR);
    end
    n_tests++;
    if (bif.MEM_WE !== 4'd0 || bif.MEM_DI !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_we_di we=%h di=%h required 0/0", bif.MEM_WE, bif.MEM_DI);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b0 || bif.VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release busy=%b valid=%b required 0/0", busy, bif.VALID);
    end
  endtask

  task automatic test_basic();
    res_t r;
    run_xfer(12'h008, 3, 32'h1, 1, r);
    n_tests++;
    if (r.timed_out || r.cycles != 5) begin
      n_fail++;
      $display("FAIL basic_latency cycles=%0d required 5", r.cycles);
    end
    n_tests++;
    if (r.first_vld != 2) begin
      n_fail++;
      $display("FAIL basic_first_valid cycle=%0d required 2", r.first_vld);
    end
    n_tests++;
    if (stream_errs() != 0 || got_d.size() != 3 || got_d[0] !== 32'h02020202) begin
      n_fail++;
      $display("FAIL basic_stream errs=%0d words=%0d required 0/3", stream_errs(), got_d.size());
    end
    n_tests++;
    if (r.busy_at_done !== 1'b0 || r.max_off != 12) begin
      n_fail++;
      $display("FAIL basic_busy_reads busy=%b max_off=%0d required 0/12", r.busy_at_done, r.max_off);
    end
  endtask

  task automatic test_ready_toggle();
    res_t r;
    run_xfer(12'h008, 3, 32'b101001, 6, r);
    n_tests++;
    if (r.timed_out || stream_errs() != 0) begin
      n_fail++;
      $display("FAIL toggle_stream errs=%0d timeout=%b required 0/0", stream_errs(), r.timed_out);
    end
    n_tests++;
    if (r.stall_err != 0 || r.max_off != 12) begin
      n_fail++;
      $display("FAIL toggle_hold stall_err=%0d max_off=%0d required 0/12", r.stall_err, r.max_off);
    end
  endtask

  task automatic test_backpressure();
    got_d.delete(); got_l.delete();
    build_exp(12'h100, 8);
    bif.READY = 1'b0;
    start = 1'b1; base = 12'h100; len = LEN_W'(8);
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    n_tests++;
    if (bif.MEM_ADDR !== {1'b0, 12'h110, 3'b000}) begin
      n_fail++;
      $display("FAIL bp_reads addr=%h required %h", bif.MEM_ADDR, {1'b0, 12'h110, 3'b000});
    end
    n_tests++;
    if (bif.VALID !== 1'b1 || bif.DATA !== exp_d[0] || got_d.size() != 0) begin
      n_fail++;
      $display("FAIL bp_head valid=%b data=%h required 1/%h", bif.VALID, bif.DATA, exp_d[0]);
    end
    bif.READY = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done) break;
    end
    n_tests++;
    if (done !== 1'b1 || stream_errs() != 0) begin
      n_fail++;
      $display("FAIL bp_stream done=%b errs=%0d required 1/0", done, stream_errs());
    end
  endtask

  task automatic test_wrap();
    got_d.delete(); got_l.delete();
    build_exp(12'hFFC, 2);
    bif.READY = 1'b1;
    start = 1'b1; base = 12'hFFC; len = LEN_W'(2);
    step();
    start = 1'b0;
    n_tests++;
    if (bif.MEM_ADDR !== 16'h7FE0) begin
      n_fail++;
      $display("FAIL wrap_addr0 addr=%h required 7fe0", bif.MEM_ADDR);
    end
    step();
    n_tests++;
    if (bif.MEM_ADDR !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_addr1 addr=%h required 0000", bif.MEM_ADDR);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) break;
    end
    n_tests++;
    if (done !== 1'b1 || stream_errs() != 0 || exp_d[0] !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL wrap_stream done=%b errs=%0d required 1/0", done, stream_errs());
    end
  endtask

  task automatic test_len_zero();
    bit seen;
    got_d.delete(); got_l.delete();
    start = 1'b1; base = 12'h010; len = '0;
    step();
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_done done=%b busy=%b required 1/0", done, busy);
    end
    step();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_pulse done=%b required 0", done);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bif.VALID || busy) seen = 1'b1;
      step();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_quiet valid_or_busy=%b required 0", seen);
    end
  endtask

  task automatic test_start_busy();
    got_d.delete(); got_l.delete();
    build_exp(12'h020, 4);
    bif.READY = 1'b0;
    start = 1'b1; base = 12'h020; len = LEN_W'(4);
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; base = 12'h400; len = LEN_W'(9);
    step();
    start = 1'b0;
    bif.READY = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done) break;
    end
    n_tests++;
    if (done !== 1'b1 || stream_errs() != 0) begin
      n_fail++;
      $display("FAIL busy_start_stream done=%b errs=%0d required 1/0", done, stream_errs());
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || bif.VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_idle busy=%b valid=%b required 0/0", busy, bif.VALID);
    end
  endtask

  task automatic test_reset_mid();
    bif.READY = 1'b1;
    start = 1'b1; base = 12'h080; len = LEN_W'(6);
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, bif.VALID, bif.LAST} !== 4'b0000 || bif.DATA !== 32'd0 ||
        bif.MEM_ADDR !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid ctrl=%b data=%h addr=%h required 0000/0/0",
               {busy, done, bif.VALID, bif.LAST}, bif.DATA, bif.MEM_ADDR);
    end
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bif.VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after busy=%b done=%b valid=%b required 0/0/0", busy, done, bif.VALID);
    end
  endtask

  task automatic test_random();
    res_t        r;
    logic [11:0] b;
    int          n;
    bit          full_rate;
    for (int w = 0; w < 1024; w++) mem[w] = $urandom;
    for (int it = 0; it < 12; it++) begin
      b = 12'($urandom);
      n = $urandom_range(1, 40);
      full_rate = it[0];
      run_xfer(b, n, 32'h1, full_rate ? 1 : 0, r);
      n_tests++;
      if (r.timed_out || stream_errs() != 0 || r.stall_err != 0) begin
        n_fail++;
        $display("FAIL rand_stream it=%0d errs=%0d stall=%0d timeout=%b required 0/0/0",
                 it, stream_errs(), r.stall_err, r.timed_out);
      end
      n_tests++;
      if (r.max_off != 4 * n || (full_rate && r.cycles != n + 2)) begin
        n_fail++;
        $display("FAIL rand_timing it=%0d max_off=%0d cycles=%0d required %0d/%0d",
                 it, r.max_off, r.cycles, 4 * n, n + 2);
      end
    end
  endtask

`ifdef HM_READER_ABORT_EN
  task automatic test_abort();
    res_t r;
    bit   seen;
    got_d.delete(); got_l.delete();
    build_exp(12'h040, 6);
    bif.READY = 1'b1;
    start = 1'b1; base = 12'h040; len = LEN_W'(6);
    step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (got_d.size() >= 2) break;
      step();
    end
    n_tests++;
    if (got_d.size() != 2) begin
      n_fail++;
      $display("FAIL abort_pre words=%0d required 2", got_d.size());
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_tests++;
    if (bif.VALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state valid=%b busy=%b done=%b required 0/0/0", bif.VALID, busy, done);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done || bif.VALID || busy) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || got_d.size() != 2 || got_d[1] !== exp_d[1]) begin
      n_fail++;
      $display("FAIL abort_quiet activity=%b words=%0d required 0/2", seen, got_d.size());
    end
    run_xfer(12'h300, 5, 32'h1, 1, r);
    n_tests++;
    if (r.timed_out || r.cycles != 7 || stream_errs() != 0) begin
      n_fail++;
      $display("FAIL abort_restart cycles=%0d errs=%0d required 7/0", r.cycles, stream_errs());
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    load_pattern();
    test_basic();
    test_ready_toggle();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_start_busy();
    test_reset_mid();
    test_random();
`ifdef HM_READER_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hm_memory_reader.md
Name: hm_memory_reader

Overview:
- Read-side client for one port of the hm_memory_32 dual-port byte memory.
- On START, fetches LEN consecutive 32-bit words beginning at byte index BASE and presents them on a valid/ready stream with backpressure.
- Absorbs the memory's 1-cycle synchronous read latency with a small output FIFO.
- Sits between hm_memory_32 port B and any consumer (e.g. a packet transmitter) that streams memory contents out.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2); issue is throttled so the FIFO never overflows.
- LEN_W, 11, width of LEN; max transfer 2^(LEN_W-1) = 1024 words.

Ports:
- CLK  in  1  system clock; memory port clock tied to the same net.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  start pulse; sampled only in IDLE.
- BASE  in  12  start byte index; must be a multiple of 4, bits [1:0] ignored.
- LEN  in  LEN_W  word count; valid values 0..1024.
- BUSY  out  1  high while not IDLE.
- DONE  out  1  one-cycle pulse at transfer completion.
- MEM_ADDR  out  16  to memory ADDR; {1'b0, byte_index[11:0], 3'b000}.
- MEM_WE  out  4  to memory WE; constant 4'b0000.
- MEM_DI  out  32  to memory DI; constant 0.
- MEM_DO  in  32  from memory DO; valid in the cycle after the edge that sampled MEM_ADDR.
- DATA  out  32  stream word (FIFO head).
- VALID  out  1  stream valid.
- READY  in  1  consumer ready; transfer when VALID&&READY at a rising edge.
- LAST  out  1  high with the final word of the transfer.

Behaviour:
- Reset: BUSY=0, DONE=0, VALID=0, LAST=0, DATA=0, MEM_ADDR=0. FIFO, counters and in-flight flag are cleared; state=IDLE. Reset asserted mid-transfer aborts it with no DONE.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - START && LEN!=0: latch byte_index=BASE&~3 and remaining=LEN, then go to RUN.
  - START && LEN==0: pulse DONE in the next cycle and stay in IDLE.
- RUN:
  - A read issues at a rising edge when fifo_count + inflight < DEPTH. inflight is 1 if a read issued at the previous edge.
  - On issue: byte_index += 4 (wraps mod 4096), remaining -= 1, inflight set.
  - When remaining reaches 0, go to DRAIN.
  - MEM_ADDR always reflects the current byte_index.
- Capture: the edge after an issue pushes MEM_DO into the FIFO. A push and a pop at the same edge are both honoured (count unchanged).
- Stream:
  - VALID = fifo_count!=0; DATA = FIFO head.
  - DATA, VALID and LAST are held stable while VALID && !READY.
  - LAST is high when the head is word number LEN, tracked by a tag bit written at push.
- DRAIN: when the LAST word is popped (VALID&&READY&&LAST), go to IDLE, pulse DONE for 1 cycle and drop BUSY in the same cycle.
- Latency: START sampled at edge 0 → first read issued at edge 1 → VALID high after edge 2. With READY held high: 1 word/cycle, LEN+2 cycles from START edge to DONE.
- START while BUSY is ignored. BASE and LEN changes after START are ignored.
- Wrap: BASE=0xFFC with LEN=2 reads index 0xFFC, then 0x000.

Optional Feature:
- HM_READER_ABORT_EN. When defined, adds input ABORT (1 bit).
- ABORT high at an edge in RUN or DRAIN:
  - flushes the FIFO and discards any in-flight capture;
  - returns to IDLE with VALID=0 in the next cycle;
  - DONE is not pulsed.
- ABORT in IDLE has no effect, and ABORT has priority over a simultaneous pop.
- When not defined, the port is absent and the logic is removed.

Test Plan:
- Memory preloaded so byte d = d/4. BASE=8, LEN=3, READY=1 → DATA 0x02020202, 0x03030303, 0x04040404 on consecutive cycles; LAST on the third; DONE 1 cycle after it; BUSY low with DONE.
- Same transfer with READY toggling 1,0,0,1,0,1 → identical word sequence, no duplicates or drops; DATA held while stalled; MEM_ADDR never issues beyond 3 reads.
- READY=0 for 10 cycles with LEN=8 → exactly DEPTH=4 reads issued, then stall. After READY=1, all 8 words arrive in order.
- BASE=0xFFC, LEN=2 → MEM_ADDR 0x7FE0 then 0x0000; data 0x3FFF... (byte 0xFFC..0xFFF = 0xFF) i.e. 0xFFFFFFFF, then 0x00000000.
- LEN=0 START → DONE pulse next cycle, VALID never asserts. START during BUSY → ignored. RST_N low mid-RUN → all outputs 0 immediately.
- Abort macro defined: ABORT after 2 words accepted of LEN=6 → VALID=0 next cycle, no DONE, BUSY=0. A new START then runs cleanly.
